// File: rtl/astream_upsizer.sv
// Narrow-to-wide stream packer: gathers IN_BITS beats little-endian into one
// PAYLOAD_BITS word, with early flush on last_in and a single registered output slot.
module astream_upsizer #(
    parameter  int IN_BITS      = 8,
    parameter  int PAYLOAD_BITS = 32,
    localparam int RATIO        = PAYLOAD_BITS / IN_BITS,
    localparam int CNT_BITS     = $clog2(RATIO) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IN_BITS-1:0]      din,
    input  logic                    val_in,
    input  logic                    last_in,
    output logic                    ready_upward,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    val_out,
    output logic                    last_out,
    output logic [CNT_BITS-1:0]     valid_lanes,
    input  logic                    ready_downward
);

    if ((PAYLOAD_BITS % IN_BITS) != 0 || RATIO < 2) begin : g_bad_params
        $error("astream_upsizer: PAYLOAD_BITS must be a multiple of IN_BITS with RATIO >= 2");
    end

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_e;

    typedef enum logic {
        ACC_IDLE,
        ACC_FILL
    } acc_state_e;

    out_state_e              r_out_state;
    out_state_e              w_out_next;
    acc_state_e              r_acc_state;
    acc_state_e              w_acc_next;

    logic [CNT_BITS-1:0]     r_idx;
    logic [PAYLOAD_BITS-1:0] r_acc;
    logic [PAYLOAD_BITS-1:0] r_dout;
    logic [CNT_BITS-1:0]     r_valid_lanes;
    logic                    r_last_out;

    logic [PAYLOAD_BITS-1:0] w_merged;
    logic                    w_val_out;
    logic                    w_beat_acc;
    logic                    w_complete;
    logic                    w_xfer;

    assign w_val_out    = (r_out_state == OUT_FULL);
    assign ready_upward = !w_val_out || ready_downward;
    assign w_beat_acc   = val_in && ready_upward;
    assign w_complete   = w_beat_acc && (last_in || (r_idx == CNT_BITS'(RATIO - 1)));
    assign w_xfer       = w_val_out && ready_downward;

    // Accumulator with the current beat dropped into lane r_idx; upper lanes stay zero.
    always_comb begin
        w_merged = r_acc;
        for (int k = 0; k < RATIO; k++) begin
            if (r_idx == CNT_BITS'(k)) begin
                w_merged[k*IN_BITS +: IN_BITS] = din;
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_out_next = r_out_state;
        case (r_out_state)
            OUT_EMPTY: if (w_complete) w_out_next = OUT_FULL;
            OUT_FULL:  if (w_xfer && !w_complete) w_out_next = OUT_EMPTY;
            default:   w_out_next = OUT_EMPTY;
        endcase
    end

    always_comb begin
        w_acc_next = r_acc_state;
        case (r_acc_state)
            ACC_IDLE: if (w_beat_acc && !w_complete) w_acc_next = ACC_FILL;
            ACC_FILL: if (w_complete) w_acc_next = ACC_IDLE;
            default:  w_acc_next = ACC_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_state <= OUT_EMPTY;
            r_acc_state <= ACC_IDLE;
        end else begin
            r_out_state <= w_out_next;
            r_acc_state <= w_acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (w_complete) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (w_beat_acc) begin
            r_idx <= r_idx + CNT_BITS'(1);
            r_acc <= w_merged;
        end
    end

    // Output slot only loads on completion; it is otherwise held, which keeps it stable under back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout        <= '0;
            r_valid_lanes <= '0;
            r_last_out    <= 1'b0;
        end else if (w_complete) begin
            r_dout        <= w_merged;
            r_valid_lanes <= r_idx + CNT_BITS'(1);
            r_last_out    <= last_in;
        end
    end

    assign dout        = r_dout;
    assign val_out     = w_val_out;
    assign last_out    = r_last_out;
    assign valid_lanes = r_valid_lanes;

endmodule

// File: tb/tb_astream_upsizer.sv
// Scoreboard bench for astream_upsizer: a beat-level packing model pushes expected
// words as beats are accepted; a monitor pops and compares on every output transfer.
module tb_astream_upsizer;

    localparam int IN_BITS      = 8;
    localparam int PAYLOAD_BITS = 32;
    localparam int RATIO        = PAYLOAD_BITS / IN_BITS;
    localparam int CNT_BITS     = $clog2(RATIO) + 1;

    logic                    clk;
    logic                    reset;
    logic [IN_BITS-1:0]      din;
    logic                    val_in;
    logic                    last_in;
    logic                    ready_upward;
    logic [PAYLOAD_BITS-1:0] dout;
    logic                    val_out;
    logic                    last_out;
    logic [CNT_BITS-1:0]     valid_lanes;
    logic                    ready_downward;

    astream_upsizer #(
        .IN_BITS      (IN_BITS),
        .PAYLOAD_BITS (PAYLOAD_BITS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .val_in         (val_in),
        .last_in        (last_in),
        .ready_upward   (ready_upward),
        .dout           (dout),
        .val_out        (val_out),
        .last_out       (last_out),
        .valid_lanes    (valid_lanes),
        .ready_downward (ready_downward)
    );

    typedef struct {
        logic [PAYLOAD_BITS-1:0] data;
        int                      lanes;
        logic                    last;
        int                      cyc;
        bit                      lat;
    } exp_t;

    exp_t                    sb[$];
    int                      n_checks = 0;
    int                      n_fail   = 0;
    int                      n_words  = 0;
    int                      cyc      = 0;
    logic [PAYLOAD_BITS-1:0] m_acc    = '0;
    int                      m_idx    = 0;
    bit                      lat_en   = 1'b1;
    bit                      rand_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: a word transfers at the next edge when val_out && ready_downward.
    always @(negedge clk) begin
        if (!reset && val_out && ready_downward) begin
            if (sb.size() == 0) begin
                check("unexpected_word", dout, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dout", dout, e.data);
                check("valid_lanes", 32'(valid_lanes), 32'(e.lanes));
                check("last_out", 32'(last_out), 32'(e.last));
                if (e.lat) check("latency_cycle", 32'(cyc), 32'(e.cyc));
                n_words++;
            end
        end
    end

    // Drive one beat and hold it until accepted; update the packing model on acceptance.
    task automatic send_beat(input logic [IN_BITS-1:0] d, input logic l);
        int t;
        bit lat;
        din     = d;
        last_in = l;
        val_in  = 1'b1;
        @(negedge clk);
        t = 0;
        while (!ready_upward && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!ready_upward) begin
            check("accept_timeout", 32'(ready_upward), 1);
            val_in = 1'b0;
            return;
        end
        lat = lat_en && ready_downward;
        @(posedge clk);
        #1;
        m_acc[m_idx*IN_BITS +: IN_BITS] = d;
        if (l || m_idx == RATIO - 1) begin
            sb.push_back('{data: m_acc, lanes: m_idx + 1, last: l, cyc: cyc, lat: lat});
            m_acc = '0;
            m_idx = 0;
        end else begin
            m_idx++;
        end
        val_in  = 1'b0;
        last_in = 1'b0;
    endtask

    task automatic apply_reset();
        val_in  = 1'b0;
        last_in = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_val_out", 32'(val_out), 0);
        check("rst_dout", dout, 0);
        check("rst_last_out", 32'(last_out), 0);
        check("rst_valid_lanes", 32'(valid_lanes), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_acc = '0;
        m_idx = 0;
        sb.delete();
        @(negedge clk);
        check("post_rst_ready_upward", 32'(ready_upward), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 32'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        din            = '0;
        val_in         = 1'b0;
        last_in        = 1'b0;
        ready_downward = 1'b1;
        reset          = 1'b1;
        #1;
        apply_reset();

        // Full word, exactly one cycle of val_out.
        w0 = n_words;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        @(negedge clk);
        check("t1_val_out_on", 32'(val_out), 1);
        check("t1_dout_const", dout, 32'h4433_2211);
        @(negedge clk);
        check("t1_val_out_off", 32'(val_out), 0);
        drain();
        check("t1_words", 32'(n_words - w0), 1);

        // Early flush after two beats, then single-beat message.
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        drain();
        send_beat(8'h5C, 1'b1);
        @(negedge clk);
        check("t3_dout_const", dout, 32'h0000_005C);
        check("t3_lanes_const", 32'(valid_lanes), 1);
        drain();

        // Back-pressure: first word held, upstream stalled, then released.
        w0 = n_words;
        ready_downward = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(IN_BITS'(8'h11 * (i + 1)), 1'b0);
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!val_out && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                check("bp_val_out", 32'(val_out), 1);
                repeat (4) begin
                    @(negedge clk);
                    check("bp_ready_upward", 32'(ready_upward), 0);
                    check("bp_dout_held", dout, 32'h4433_2211);
                end
                @(posedge clk);
                #1;
                ready_downward = 1'b1;
            end
        join
        drain();
        check("bp_words", 32'(n_words - w0), 2);

        // Continuous streaming at full rate.
        w0 = n_words;
        fork
            begin
                for (int i = 1; i <= 8; i++) send_beat(IN_BITS'(i), 1'b0);
            end
            begin
                repeat (8) begin
                    @(negedge clk);
                    check("stream_ready_upward", 32'(ready_upward), 1);
                end
            end
        join
        drain();
        check("stream_words", 32'(n_words - w0), 2);

        // Reset mid-word: the two pre-reset beats must vanish.
        send_beat(8'h99, 1'b0);
        send_beat(8'hA5, 1'b0);
        apply_reset();
        w0 = n_words;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        @(negedge clk);
        check("rst_mid_dout", dout, 32'h4433_2211);
        drain();
        check("rst_mid_words", 32'(n_words - w0), 1);

        // Random beats, random last, random back-pressure.
        lat_en    = 1'b0;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    send_beat(IN_BITS'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                send_beat(8'hE7, 1'b1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    ready_downward = ($urandom_range(0, 2) != 0);
                end
                ready_downward = 1'b1;
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
